add_sub_seq_ctrl: RTL and testbench

Iterative multi-word adder/subtractor controller. It computes a WIDTH-bit A+B or A-B over WIDTH/4 cycles by sequencing one shared 4-bit carry-chained slice, least significant nibble first, with a carry register between nibbles. It sits between an operation issuer (start/done handshake) and the 4-bit arithmetic datapath. Wide operands therefore cost latency, not area.

---
 rtl/add_sub_seq_ctrl_pkg.sv | 18 +
 rtl/add_sub_seq_ctrl_if.sv | 32 +++
 rtl/add_sub_seq_ctrl_slice.sv | 37 +++
 rtl/add_sub_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_add_sub_seq_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/add_sub_seq_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
package add_sub_pkg;

  // Width of the shared arithmetic slice.
  localparam int NIBBLE_W = 4;

  // Operation encoding on the op input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_sub_seq_ctrl_if.sv
// Issuer-side bus of the add/subtract controller.
//
// Handshake: the issuer raises start with op/a/b stable for one clock. It is
// taken on a rising edge only while busy is low (IDLE or the DONE cycle); a
// start seen while busy is dropped, not queued. done pulses for exactly one
// cycle when result/cout/overflow become valid. Those outputs then hold until
// the next accepted start has run to completion.
interface add_sub_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  // Issuer side.
  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, overflow
  );

  // Controller side.
  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, overflow
  );
endinterface

// File: rtl/add_sub_seq_ctrl_slice.sv
// 4-bit ripple-carry slice with explicit carry-in, built from full adders.
// Any B inversion for subtraction is done by the caller, so the carry chain
// stays continuous from one nibble to the next.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module nibble_add_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    fulladder u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[4];
endmodule

// File: rtl/add_sub_seq_ctrl.sv
// Nibble-serial WIDTH-bit adder/subtractor. One 4-bit slice is reused for
// WIDTH/4 cycles, least significant nibble first, with the inter-nibble carry
// held in carry_q. Subtraction is A + ~B + 1: B is inverted per nibble and
// the initial carry is 1.
module add_sub_seq_ctrl
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  add_sub_seq_ctrl_if.slave  bus,
  output state_t             state_o
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
    $error("add_sub_seq_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       x, y, sum;
  logic             s_cout;
  logic [WIDTH-1:0] acc_shift;

  // Current nibble operands; y is the effective (possibly inverted) B nibble.
  assign x = a_q[3:0];
  assign y = b_q[3:0] ^ {4{op_q}};

  nibble_add_slice u_slice (
    .x    (x),
    .y    (y),
    .cin  (carry_q),
    .sum  (sum),
    .cout (s_cout)
  );

  // Accumulator after inserting this nibble's sum at the top.
  if (WIDTH == NIBBLE_W) begin : g_acc_single
    assign acc_shift = sum;
  end else begin : g_acc_multi
    assign acc_shift = {sum, acc_q[WIDTH-1:NIBBLE_W]};
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state and datapath sequencing.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          carry_d = (bus.op == OP_SUB);
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d   = acc_shift;
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        carry_d = s_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          // Last nibble: publish the full result and MSB flags together.
          result_d = acc_shift;
          cout_d   = s_cout;
          ovf_d    = (x[3] == y[3]) && (sum[3] != x[3]);
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_add_sub_seq_ctrl.sv
// Directed and randomized checks of the nibble-serial add/subtract controller
// at WIDTH=16 and WIDTH=4.
module tb_add_sub_seq_ctrl;
  import add_sub_pkg::*;

  logic   clk;
  logic   rst;
  state_t state16, state4;
  int     n_tests;
  int     n_failed;

  add_sub_seq_ctrl_if #(.WIDTH(16)) bus16 ();
  add_sub_seq_ctrl_if #(.WIDTH(4))  bus4 ();

  add_sub_seq_ctrl #(.WIDTH(16)) dut16 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus16.slave),
    .state_o (state16)
  );

  add_sub_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus4.slave),
    .state_o (state4)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: returns {overflow, cout, result[15:0]} for width w.
  function automatic logic [17:0] model(input int w, input logic op,
                                         input logic [15:0] a, input logic [15:0] b);
    logic [31:0] mask, bb, s, r;
    logic        c, o, sa, sb, sr;
    mask = (32'd1 << w) - 32'd1;
    bb   = op ? (~{16'h0, b}) & mask : {16'h0, b};
    s    = {16'h0, a} + bb + {31'h0, op};
    r    = s & mask;
    c    = s[w];
    sa   = a[w-1];
    sb   = bb[w-1];
    sr   = r[w-1];
    o    = (sa == sb) && (sr != sa);
    return {o, c, r[15:0]};
  endfunction

  // Drivers: called at a falling edge; start is held across one rising edge.
  task automatic issue16(input logic op, input logic [15:0] a, input logic [15:0] b);
    bus16.start = 1'b1; bus16.op = op; bus16.a = a; bus16.b = b;
    @(negedge clk);
    bus16.start = 1'b0;
  endtask

  task automatic issue4(input logic op, input logic [3:0] a, input logic [3:0] b);
    bus4.start = 1'b1; bus4.op = op; bus4.a = a; bus4.b = b;
    @(negedge clk);
    bus4.start = 1'b0;
  endtask

  // Waits (bounded) for done. lat counts rising edges from the accepting edge
  // up to the edge that first captures done high; 21 means it never came.
  task automatic wait16(output int lat, output int busy_cnt);
    int n;
    n = 0; busy_cnt = 0;
    while (!bus16.done && n < 20) begin
      if (bus16.busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    lat = bus16.done ? n + 1 : 21;
  endtask

  task automatic wait4(output int lat, output int busy_cnt);
    int n;
    n = 0; busy_cnt = 0;
    while (!bus4.done && n < 20) begin
      if (bus4.busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    lat = bus4.done ? n + 1 : 21;
  endtask

  task automatic run16(input string tag, input logic op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] er,
                       input logic ec, input logic eo);
    int lat, bc;
    issue16(op, a, b);
    wait16(lat, bc);
    check({tag, "_lat"},  32'(lat), 32'd5);
    check({tag, "_busy"}, 32'(bc), 32'd4);
    check({tag, "_res"},  32'(bus16.result), 32'(er));
    check({tag, "_cout"}, 32'(bus16.cout), 32'(ec));
    check({tag, "_ovf"},  32'(bus16.overflow), 32'(eo));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus16.done), 32'd0);
  endtask

  task automatic run4(input string tag, input logic op, input logic [3:0] a,
                      input logic [3:0] b, input logic [3:0] er,
                      input logic ec, input logic eo);
    int lat, bc;
    issue4(op, a, b);
    wait4(lat, bc);
    check({tag, "_lat"},  32'(lat), 32'd2);
    check({tag, "_busy"}, 32'(bc), 32'd1);
    check({tag, "_res"},  32'(bus4.result), 32'(er));
    check({tag, "_cout"}, 32'(bus4.cout), 32'(ec));
    check({tag, "_ovf"},  32'(bus4.overflow), 32'(eo));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus4.done), 32'd0);
  endtask

  initial begin
    int          lat, bc;
    logic        done_seen;
    logic [17:0] m;
    logic        rop;
    logic [15:0] ra, rb;

    n_tests = 0; n_failed = 0;
    rst = 1'b1;
    bus16.start = 1'b0; bus16.op = 1'b0; bus16.a = '0; bus16.b = '0;
    bus4.start  = 1'b0; bus4.op  = 1'b0; bus4.a  = '0; bus4.b  = '0;

    // Reset state, with start asserted during reset to show it is ignored.
    repeat (2) @(negedge clk);
    bus16.start = 1'b1; bus16.a = 16'h1111; bus16.b = 16'h2222;
    @(negedge clk);
    check("rst_busy",  32'(bus16.busy), 32'd0);
    check("rst_done",  32'(bus16.done), 32'd0);
    check("rst_res",   32'(bus16.result), 32'd0);
    check("rst_cout",  32'(bus16.cout), 32'd0);
    check("rst_ovf",   32'(bus16.overflow), 32'd0);
    check("rst_state", 32'(state16), 32'(IDLE));
    check("rst_res4",  32'(bus4.result), 32'd0);
    bus16.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(bus16.busy), 32'd0);

    // Directed add/sub vectors.
    run16("add_basic", OP_ADD, 16'h1234, 16'h0FCC, 16'h2200, 1'b0, 1'b0);
    run16("sub_borrow", OP_SUB, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    run16("sub_ovf", OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
    run16("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    run16("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);

    // Start during RUN is ignored; outputs hold until completion.
    issue16(OP_ADD, 16'h0001, 16'h0001);
    @(negedge clk);
    bus16.start = 1'b1; bus16.op = OP_SUB; bus16.a = 16'hAAAA; bus16.b = 16'h5555;
    @(negedge clk);
    bus16.start = 1'b0;
    check("ign_hold_res",  32'(bus16.result), 32'h0000);
    check("ign_hold_cout", 32'(bus16.cout), 32'd1);
    wait16(lat, bc);
    check("ign_done", 32'(lat < 21), 32'd1);
    check("ign_res",  32'(bus16.result), 32'h0002);
    check("ign_cout", 32'(bus16.cout), 32'd0);
    // Start in the DONE cycle is accepted.
    issue16(OP_ADD, 16'h0003, 16'h0004);
    wait16(lat, bc);
    check("b2b_lat", 32'(lat), 32'd5);
    check("b2b_res", 32'(bus16.result), 32'h0007);
    @(negedge clk);

    // Asynchronous reset in RUN cycle 3 aborts with no done pulse.
    issue16(OP_ADD, 16'h7FFF, 16'h0001);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus16.start = 1'b1;
    #1;
    check("abort_busy", 32'(bus16.busy), 32'd0);
    check("abort_done", 32'(bus16.done), 32'd0);
    check("abort_res",  32'(bus16.result), 32'd0);
    check("abort_cout", 32'(bus16.cout), 32'd0);
    check("abort_ovf",  32'(bus16.overflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus16.start = 1'b0;
    done_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus16.done || bus16.busy) done_seen = 1'b1;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    run16("after_abort", OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);

    // WIDTH=4 instance.
    run4("w4_sub", OP_SUB, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0);
    run4("w4_add_ovf", OP_ADD, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1);

    // Randomized ops against the reference model.
    for (int i = 0; i < 12; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = 16'($urandom_range(0, 65535));
      rb  = 16'($urandom_range(0, 65535));
      m   = model(16, rop, ra, rb);
      run16($sformatf("rnd16_%0d", i), rop, ra, rb, m[15:0], m[16], m[17]);
    end
    for (int i = 0; i < 12; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = 16'($urandom_range(0, 15));
      rb  = 16'($urandom_range(0, 15));
      m   = model(4, rop, ra, rb);
      run4($sformatf("rnd4_%0d", i), rop, ra[3:0], rb[3:0], m[3:0], m[16], m[17]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
